// File: rtl/data_mem_arb.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Performs sub-word loads (with sign/zero extension) and read-modify-write sub-word stores.
module data_mem_arb #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              wr0_i,
  input  logic [2:0]        memop0_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       wdata0_i,
  input  logic              req1_i,
  input  logic              wr1_i,
  input  logic [2:0]        memop1_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata1_i,
  output logic              gnt0_o,
  output logic              done0_o,
  output logic              err0_o,
  output logic [31:0]       rdata0_o,
  output logic              gnt1_o,
  output logic              done1_o,
  output logic              err1_o,
  output logic [31:0]       rdata1_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP} state_e;

  state_e              state_q;
  logic                last_q, own_q, wr_q, err_q;
  logic [2:0]          op_q;
  logic [1:0]          off_q;
  logic [HALF_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rslt_q;
  logic                gnt0_q, gnt1_q, done0_q, done1_q, err0_q, err1_q, busy_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_en_q, mem_wr_en_q;

  logic                any_req_c, pick1_c, wr_c, illegal_c, word_store_c;
  logic [2:0]          op_c;
  logic [31:0]         addr_c, wdata_c;
  logic [7:0]          byte_c;
  logic [HALF_W-1:0]   half_c;
  logic [DATA_W-1:0]   load_c, store_c;
  logic                unused_addr_c;

  // Requester selection: on a tie the one not granted last wins.
  always_comb begin
    any_req_c    = req0_i | req1_i;
    pick1_c      = req1_i & (~req0_i | ~last_q);
    wr_c         = pick1_c ? wr1_i    : wr0_i;
    op_c         = pick1_c ? memop1_i : memop0_i;
    addr_c       = pick1_c ? addr1_i  : addr0_i;
    wdata_c      = pick1_c ? wdata1_i : wdata0_i;
    word_store_c = wr_c & (op_c == 3'b010);
    illegal_c    = 1'b1;
    case (op_c)
      3'b000:  illegal_c = 1'b0;
      3'b001:  illegal_c = addr_c[0];
      3'b010:  illegal_c = |addr_c[1:0];
      3'b100:  illegal_c = wr_c;
      3'b101:  illegal_c = wr_c | addr_c[0];
      default: illegal_c = 1'b1;
    endcase
  end

  assign unused_addr_c = ^addr_c[31:ADDR_W+2];

  // Lane extraction for loads and lane insertion for read-modify-write stores.
  always_comb begin
    case (off_q)
      2'd0:    byte_c = mem_rdata_i[7:0];
      2'd1:    byte_c = mem_rdata_i[15:8];
      2'd2:    byte_c = mem_rdata_i[23:16];
      default: byte_c = mem_rdata_i[31:24];
    endcase
    half_c = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q[1:0])
      2'b00:   load_c = {{24{~op_q[2] & byte_c[7]}}, byte_c};
      2'b01:   load_c = {{16{~op_q[2] & half_c[15]}}, half_c};
      default: load_c = mem_rdata_i;
    endcase
    store_c = mem_rdata_i;
    if (op_q[1:0] == 2'b00) begin
      case (off_q)
        2'd0:    store_c[7:0]   = wdata_q[7:0];
        2'd1:    store_c[15:8]  = wdata_q[7:0];
        2'd2:    store_c[23:16] = wdata_q[7:0];
        default: store_c[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      store_c[31:16] = wdata_q;
    end else begin
      store_c[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      own_q       <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      rslt_q      <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      busy_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
    end else begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= any_req_c;
          if (any_req_c) begin
            own_q      <= pick1_c;
            gnt0_q     <= ~pick1_c;
            gnt1_q     <= pick1_c;
            wr_q       <= wr_c;
            op_q       <= op_c;
            off_q      <= addr_c[1:0];
            wdata_q    <= wdata_c[HALF_W-1:0];
            mem_addr_q <= addr_c[ADDR_W+1:2];
            err_q      <= illegal_c;
            rslt_q     <= '0;
            if (illegal_c) begin
              state_q <= S_RESP;
            end else if (word_store_c) begin
              state_q     <= S_WRITE;
              mem_wdata_q <= wdata_c;
              mem_wr_en_q <= 1'b1;
            end else begin
              state_q     <= S_READ;
              mem_rd_en_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          busy_q  <= 1'b1;
          state_q <= S_MERGE;
        end
        S_MERGE: begin
          busy_q <= 1'b1;
          if (wr_q) begin
            mem_wdata_q <= store_c;
            mem_wr_en_q <= 1'b1;
            state_q     <= S_WRITE;
          end else begin
            rslt_q  <= load_c;
            state_q <= S_RESP;
          end
        end
        S_WRITE: begin
          busy_q  <= 1'b1;
          state_q <= S_RESP;
        end
        default: begin
          busy_q  <= 1'b0;
          last_q  <= own_q;
          state_q <= S_IDLE;
          if (own_q) begin
            done1_q  <= 1'b1;
            err1_q   <= err_q;
            rdata1_q <= rslt_q;
          end else begin
            done0_q  <= 1'b1;
            err0_q   <= err_q;
            rdata0_q <= rslt_q;
          end
        end
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign err0_o      = err0_q;
  assign err1_o      = err1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_wr_en_o = mem_wr_en_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arb.sv
// Bench for data_mem_arb: transaction-level reference model with a per-cycle compare,
// plus directed vectors whose latency/data/error are pinned by hand-computed literals.
module tb_data_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
  logic [2:0]  op0 = 0, op1 = 0;
  logic [31:0] addr0 = 0, wd0 = 0, addr1 = 0, wd1 = 0;
  logic        gnt0, done0, err0, gnt1, done1, err1, busy, mem_rd_en, mem_wr_en;
  logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  data_mem_arb #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .wr0_i(wr0), .memop0_i(op0), .addr0_i(addr0), .wdata0_i(wd0),
    .req1_i(req1), .wr1_i(wr1), .memop1_i(op1), .addr1_i(addr1), .wdata1_i(wd1),
    .gnt0_o(gnt0), .done0_o(done0), .err0_o(err0), .rdata0_o(rdata0),
    .gnt1_o(gnt1), .done1_o(done1), .err1_o(err1), .rdata1_o(rdata1),
    .busy_o(busy), .mem_addr_o(mem_addr), .mem_rd_en_o(mem_rd_en),
    .mem_wr_en_o(mem_wr_en), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory the DUT drives.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input bit wr, input bit [2:0] op, input bit [31:0] a);
    case (op)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !wr;
      3'd5:    return !wr && (a % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int latency(input bit legal, input bit wr, input bit [2:0] op);
    if (!legal) return 1;
    if (wr && op == 3'd2) return 2;
    if (!wr) return 3;
    return 4;
  endfunction

  function automatic bit [31:0] load_val(input bit [31:0] w, input bit [2:0] op, input bit [31:0] a);
    bit [31:0] v;
    int sh = int'(a % 4) * 8;
    if (op == 3'd0 || op == 3'd4) begin
      v = (w >> sh) & 32'hFF;
      if (op == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op == 3'd1 || op == 3'd5) begin
      v = (w >> sh) & 32'hFFFF;
      if (op == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  function automatic bit [31:0] store_val(input bit [31:0] w, input bit [2:0] op, input bit [31:0] a, input bit [31:0] wd);
    bit [31:0] mask;
    int sh = int'(a % 4) * 8;
    mask = (op == 3'd0) ? 32'hFF : (op == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // Reference model state: at most one transaction outstanding.
  bit        m_act, m_own, m_err, m_wr, m_last;
  int        m_done, m_word, m_rd_cnt, m_wr_cnt, m_exp_rd, m_exp_wr;
  bit [31:0] m_rdata, m_new, hold0, hold1;
  bit        p_valid, p_idle, p_r0, p_r1;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctrl", {gnt0, gnt1, done0, done1, err0, err1, busy, mem_rd_en, mem_wr_en}, 0);
      check("rst_data", {rdata0, rdata1}, 0);
      check("rst_mem", {mem_wdata, mem_addr}, 0);
      m_act = 0; m_last = 1; hold0 = 0; hold1 = 0; p_valid = 0;
    end else begin
      bit eg0, eg1, ed0, ed1, own, legal, wr;
      bit [2:0]  op;
      bit [31:0] a, wd;
      cyc++;
      eg0 = 0; eg1 = 0; ed0 = 0; ed1 = 0;
      if (p_valid && p_idle && (p_r0 || p_r1)) begin
        own = (p_r0 && p_r1) ? !m_last : p_r1;
        m_last = own;
        wr = own ? wr1 : wr0; op = own ? op1 : op0;
        a  = own ? addr1 : addr0; wd = own ? wd1 : wd0;
        legal    = is_legal(wr, op, a);
        m_act    = 1; m_own = own; m_err = !legal; m_wr = wr;
        m_word   = int'((a >> 2) % 256);
        m_done   = cyc + latency(legal, wr, op);
        m_rdata  = (legal && !wr) ? load_val(shadow[m_word], op, a) : 32'h0;
        m_new    = store_val(shadow[m_word], op, a, wd);
        m_exp_rd = (legal && !(wr && op == 3'd2)) ? 1 : 0;
        m_exp_wr = (legal && wr) ? 1 : 0;
        m_rd_cnt = 0; m_wr_cnt = 0;
        eg0 = !own; eg1 = own;
      end
      check("gnt0", gnt0, eg0);
      check("gnt1", gnt1, eg1);
      check("strobe_excl", mem_rd_en & mem_wr_en, 0);
      if (m_act) begin
        m_rd_cnt += int'(mem_rd_en);
        m_wr_cnt += int'(mem_wr_en);
        if (!m_err && cyc < m_done) check("mem_addr", mem_addr, m_word);
        if (mem_wr_en) check("mem_wdata", mem_wdata, m_new);
      end else check("idle_strobes", {mem_rd_en, mem_wr_en}, 0);
      if (m_act && cyc == m_done) begin
        ed0 = !m_own; ed1 = m_own;
        check("rd_strobes", m_rd_cnt, m_exp_rd);
        check("wr_strobes", m_wr_cnt, m_exp_wr);
        if (m_own) hold1 = m_rdata; else hold0 = m_rdata;
        if (m_wr && !m_err) shadow[m_word] = m_new;
      end
      check("done0", done0, ed0);
      check("done1", done1, ed1);
      check("err0", err0, ed0 & m_err);
      check("err1", err1, ed1 & m_err);
      check("rdata0", rdata0, hold0);
      check("rdata1", rdata1, hold1);
      if (ed0 || ed1) m_act = 0;
      check("busy", busy, m_act);
      p_valid = 1; p_idle = !m_act; p_r0 = req0; p_r1 = req1;
    end
  end

  task automatic txn(input bit n, input bit wr, input bit [2:0] op, input bit [31:0] a,
                     input bit [31:0] wd, output int lat, output bit [31:0] rd, output bit er);
    int g = 0;
    bit got = 0;
    lat = -1; rd = 32'hDEAD_DEAD; er = 1'bx;
    @(posedge clk); #1;
    if (n) begin req1 = 1; wr1 = wr; op1 = op; addr1 = a; wd1 = wd; end
    else   begin req0 = 1; wr0 = wr; op0 = op; addr0 = a; wd0 = wd; end
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk); #1;
      if ((n ? gnt1 : gnt0) === 1'b1) begin got = 1; g = cyc; end
    end
    @(posedge clk); #1;
    if (n) req1 = 0; else req0 = 0;
    if (!got) check("gnt_timeout", 0, 1);
    else begin
      got = 0;
      for (int k = 0; k < 30 && !got; k++) begin
        @(negedge clk); #1;
        if ((n ? done1 : done0) === 1'b1) begin
          got = 1; lat = cyc - g; rd = n ? rdata1 : rdata0; er = n ? err1 : err0;
        end
      end
      if (!got) check("done_timeout", 0, 1);
    end
  endtask

  typedef struct packed {
    bit        n;
    bit        wr;
    bit [2:0]  op;
    bit [31:0] a;
    bit [31:0] wd;
    bit [7:0]  lat;
    bit [31:0] rd;
    bit        er;
  } vec_t;

  vec_t vecs [14] = '{
    '{0, 0, 3'd4, 32'h13, 32'h0,         8'd3, 32'h0000_0088, 0},
    '{1, 0, 3'd0, 32'h13, 32'h0,         8'd3, 32'hFFFF_FF88, 0},
    '{0, 0, 3'd1, 32'h12, 32'h0,         8'd3, 32'hFFFF_8899, 0},
    '{1, 0, 3'd5, 32'h12, 32'h0,         8'd3, 32'h0000_8899, 0},
    '{0, 0, 3'd2, 32'h10, 32'h0,         8'd3, 32'h8899_1234, 0},
    '{1, 1, 3'd2, 32'h14, 32'hDEAD_BEEF, 8'd2, 32'h0,         0},
    '{0, 1, 3'd0, 32'h15, 32'h1234_56AB, 8'd4, 32'h0,         0},
    '{1, 0, 3'd2, 32'h14, 32'h0,         8'd3, 32'hDEAD_ABEF, 0},
    '{0, 0, 3'd1, 32'h11, 32'h0,         8'd1, 32'h0,         1},
    '{1, 0, 3'd3, 32'h10, 32'h0,         8'd1, 32'h0,         1},
    '{0, 1, 3'd4, 32'h10, 32'h0,         8'd1, 32'h0,         1},
    '{1, 1, 3'd2, 32'h16, 32'h0,         8'd1, 32'h0,         1},
    '{0, 1, 3'd1, 32'h16, 32'hFFFF_5566, 8'd4, 32'h0,         0},
    '{1, 0, 3'd5, 32'h16, 32'h0,         8'd3, 32'h0000_5566, 0}
  };

  initial begin
    int        lat, cnt, bad;
    bit [31:0] rd, keep;
    bit        er;
    int        order [4];
    int        gcyc  [4];
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = (32'h0101_0101 * i) ^ 32'hA5A5_0000;
      shadow[i] = (32'h0101_0101 * i) ^ 32'hA5A5_0000;
    end
    mem[4] = 32'h8899_AABB; shadow[4] = 32'h8899_AABB;
    #2 rst_n = 1'b0;
    // Tie from reset: both word loads pending.
    req0 = 1; op0 = 3'd2; addr0 = 32'h20;
    req1 = 1; op1 = 3'd2; addr1 = 32'h24;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 80 && cnt < 4; k++) begin
      @(negedge clk); #1;
      if (gnt0 === 1'b1) begin order[cnt] = 0; gcyc[cnt] = cyc; cnt++; end
      else if (gnt1 === 1'b1) begin order[cnt] = 1; gcyc[cnt] = cyc; cnt++; end
    end
    @(posedge clk); #1 req0 = 0; req1 = 0;
    check("tie_count", cnt, 4);
    check("tie_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_00_01);
    check("tie_gap", gcyc[1] - gcyc[0], 4);
    repeat (6) @(negedge clk);

    txn(0, 0, 3'd0, 32'h12, 32'h0, lat, rd, er);
    check("lb_lat", lat, 3); check("lb_rdata", rd, 32'hFFFF_FF99); check("lb_err", er, 0);
    txn(1, 1, 3'd1, 32'h10, 32'h0000_1234, lat, rd, er);
    check("sh_lat", lat, 4); check("sh_rdata", rd, 0); check("sh_err", er, 0);
    check("sh_mem", mem[4], 32'h8899_1234);
    txn(1, 0, 3'd2, 32'h02, 32'h0, lat, rd, er);
    check("lw_mis_lat", lat, 1); check("lw_mis_rdata", rd, 0); check("lw_mis_err", er, 1);

    foreach (vecs[i]) begin
      txn(vecs[i].n, vecs[i].wr, vecs[i].op, vecs[i].a, vecs[i].wd, lat, rd, er);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      check($sformatf("vec%0d_err", i), er, vecs[i].er);
    end
    check("sb_mem", mem[5], 32'h5566_ABEF);

    // Abort a byte store in its merge cycle.
    keep = mem[6];
    cnt = 0;
    @(posedge clk); #1 req0 = 1; wr0 = 1; op0 = 3'd0; addr0 = 32'h18; wd0 = 32'h77;
    for (int k = 0; k < 30 && cnt == 0; k++) begin
      @(negedge clk); #1;
      if (gnt0 === 1'b1) cnt = 1;
    end
    check("abort_gnt", cnt, 1);
    @(posedge clk); #1 req0 = 0;
    #1 rst_n = 1'b0;
    #1 check("abort_async", {busy, done0, mem_rd_en, mem_wr_en, mem_addr}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (done0 === 1'b1 || mem_wr_en === 1'b1) cnt++;
    end
    check("abort_no_done", cnt, 0);
    check("abort_mem", mem[6], keep);
    txn(0, 0, 3'd2, 32'h18, 32'h0, lat, rd, er);
    check("post_abort_lat", lat, 3); check("post_abort_rdata", rd, 32'hA3A3_0606);

    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) bad++;
    check("mem_image", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
